// File: rtl/mmu_port_arbiter.sv
// Arbitrates the single MMU data port between instruction fetch (IF) and the memory stage (DM).
// DM has fixed priority. A starvation counter forces IF through. A timeout aborts MMU transactions that hang.
module mmu_port_arbiter #(
    parameter int STARVE_LIMIT   = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_if_req,
    input  logic [31:0] i_if_address,
    output logic [31:0] o_if_rdata,
    output logic        o_if_ack,
    output logic        o_if_err,
    input  logic        i_dm_req,
    input  logic [31:0] i_dm_address,
    input  logic [31:0] i_dm_wdata,
    input  logic [3:0]  i_dm_we,
    output logic [31:0] o_dm_rdata,
    output logic        o_dm_ack,
    output logic        o_dm_err,
    output logic        mmu_req,
    output logic [31:0] mmu_address,
    output logic [31:0] mmu_output_data,
    output logic [3:0]  mmu_we,
    input  logic [31:0] mmu_input_data,
    input  logic        mmu_ready,
    output logic        o_busy
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_DM = 2'd2,
        ACK     = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] starve_cnt_q, starve_cnt_d;
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic          mmu_req_q, mmu_req_d;
    logic [31:0]   mmu_address_q, mmu_address_d;
    logic [31:0]   mmu_output_data_q, mmu_output_data_d;
    logic [3:0]    mmu_we_q, mmu_we_d;
    logic [31:0]   if_rdata_q, if_rdata_d;
    logic          if_ack_q, if_ack_d;
    logic          if_err_q, if_err_d;
    logic [31:0]   dm_rdata_q, dm_rdata_d;
    logic          dm_ack_q, dm_ack_d;
    logic          dm_err_q, dm_err_d;

    logic starved;
    logic grant_dm;
    logic grant_if;
    logic in_busy;
    logic tmo_hit;

    // IF wins a contended cycle only once DM has taken STARVE_LIMIT grants in a row over it.
    assign starved  = (starve_cnt_q == SW'(STARVE_LIMIT));
    assign grant_dm = (state_q == IDLE) && i_dm_req && !(i_if_req && starved);
    assign grant_if = (state_q == IDLE) && i_if_req && !grant_dm;
    assign in_busy  = (state_q == BUSY_IF) || (state_q == BUSY_DM);
    assign tmo_hit  = in_busy && !mmu_ready && (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (grant_dm) begin
                    state_d = BUSY_DM;
                end else if (grant_if) begin
                    state_d = BUSY_IF;
                end
            end
            BUSY_IF, BUSY_DM: begin
                if (mmu_ready || tmo_hit) begin
                    state_d = ACK;
                end
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        starve_cnt_d      = starve_cnt_q;
        tmo_cnt_d         = tmo_cnt_q;
        mmu_req_d         = mmu_req_q;
        mmu_address_d     = mmu_address_q;
        mmu_output_data_d = mmu_output_data_q;
        mmu_we_d          = mmu_we_q;
        if_rdata_d        = if_rdata_q;
        dm_rdata_d        = dm_rdata_q;
        if_ack_d          = 1'b0;
        if_err_d          = 1'b0;
        dm_ack_d          = 1'b0;
        dm_err_d          = 1'b0;

        if (grant_dm) begin
            mmu_req_d         = 1'b1;
            mmu_address_d     = i_dm_address;
            mmu_we_d          = i_dm_we;
            mmu_output_data_d = (i_dm_we == 4'b0000) ? 32'h0 : i_dm_wdata;
            tmo_cnt_d         = '0;
            if (!i_if_req) begin
                starve_cnt_d = '0;
            end else if (!starved) begin
                starve_cnt_d = starve_cnt_q + SW'(1);
            end
        end else if (grant_if) begin
            mmu_req_d         = 1'b1;
            mmu_address_d     = i_if_address;
            mmu_we_d          = 4'b0000;
            mmu_output_data_d = 32'h0;
            tmo_cnt_d         = '0;
            starve_cnt_d      = '0;
        end else if (in_busy) begin
            tmo_cnt_d = tmo_cnt_q + TW'(1);
            if (mmu_ready) begin
                mmu_req_d         = 1'b0;
                mmu_we_d          = 4'b0000;
                mmu_output_data_d = 32'h0;
                if (state_q == BUSY_IF) begin
                    if_rdata_d = mmu_input_data;
                    if_ack_d   = 1'b1;
                end else begin
                    dm_rdata_d = mmu_input_data;
                    dm_ack_d   = 1'b1;
                end
            end else if (tmo_hit) begin
                // Abort: report the error with zeroed data so the requester never consumes stale bits.
                mmu_req_d = 1'b0;
                mmu_we_d  = 4'b0000;
                if (state_q == BUSY_IF) begin
                    if_rdata_d = 32'h0;
                    if_ack_d   = 1'b1;
                    if_err_d   = 1'b1;
                end else begin
                    dm_rdata_d = 32'h0;
                    dm_ack_d   = 1'b1;
                    dm_err_d   = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_cnt_q      <= '0;
            tmo_cnt_q         <= '0;
            mmu_req_q         <= 1'b0;
            mmu_address_q     <= 32'h0;
            mmu_output_data_q <= 32'h0;
            mmu_we_q          <= 4'b0000;
            if_rdata_q        <= 32'h0;
            if_ack_q          <= 1'b0;
            if_err_q          <= 1'b0;
            dm_rdata_q        <= 32'h0;
            dm_ack_q          <= 1'b0;
            dm_err_q          <= 1'b0;
        end else begin
            starve_cnt_q      <= starve_cnt_d;
            tmo_cnt_q         <= tmo_cnt_d;
            mmu_req_q         <= mmu_req_d;
            mmu_address_q     <= mmu_address_d;
            mmu_output_data_q <= mmu_output_data_d;
            mmu_we_q          <= mmu_we_d;
            if_rdata_q        <= if_rdata_d;
            if_ack_q          <= if_ack_d;
            if_err_q          <= if_err_d;
            dm_rdata_q        <= dm_rdata_d;
            dm_ack_q          <= dm_ack_d;
            dm_err_q          <= dm_err_d;
        end
    end

    assign mmu_req         = mmu_req_q;
    assign mmu_address     = mmu_address_q;
    assign mmu_output_data = mmu_output_data_q;
    assign mmu_we          = mmu_we_q;
    assign o_if_rdata      = if_rdata_q;
    assign o_if_ack        = if_ack_q;
    assign o_if_err        = if_err_q;
    assign o_dm_rdata      = dm_rdata_q;
    assign o_dm_ack        = dm_ack_q;
    assign o_dm_err        = dm_err_q;
    assign o_busy          = (state_q != IDLE);

endmodule

// File: tb/tb_mmu_port_arbiter.sv
// Testbench for mmu_port_arbiter: directed scenarios plus a randomized run.
// The randomized run is checked against a transaction-level arbitration model.
module tb_mmu_port_arbiter;

    localparam int STARVE_LIMIT   = 4;
    localparam int TIMEOUT_CYCLES = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_if_req;
    logic [31:0] i_if_address;
    logic [31:0] o_if_rdata;
    logic        o_if_ack;
    logic        o_if_err;
    logic        i_dm_req;
    logic [31:0] i_dm_address;
    logic [31:0] i_dm_wdata;
    logic [3:0]  i_dm_we;
    logic [31:0] o_dm_rdata;
    logic        o_dm_ack;
    logic        o_dm_err;
    logic        mmu_req;
    logic [31:0] mmu_address;
    logic [31:0] mmu_output_data;
    logic [3:0]  mmu_we;
    logic [31:0] mmu_input_data;
    logic        mmu_ready;
    logic        o_busy;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mmu_port_arbiter #(
        .STARVE_LIMIT  (STARVE_LIMIT),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .i_if_req       (i_if_req),
        .i_if_address   (i_if_address),
        .o_if_rdata     (o_if_rdata),
        .o_if_ack       (o_if_ack),
        .o_if_err       (o_if_err),
        .i_dm_req       (i_dm_req),
        .i_dm_address   (i_dm_address),
        .i_dm_wdata     (i_dm_wdata),
        .i_dm_we        (i_dm_we),
        .o_dm_rdata     (o_dm_rdata),
        .o_dm_ack       (o_dm_ack),
        .o_dm_err       (o_dm_err),
        .mmu_req        (mmu_req),
        .mmu_address    (mmu_address),
        .mmu_output_data(mmu_output_data),
        .mmu_we         (mmu_we),
        .mmu_input_data (mmu_input_data),
        .mmu_ready      (mmu_ready),
        .o_busy         (o_busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_if_req       = 1'b0;
        i_if_address   = 32'h0;
        i_dm_req       = 1'b0;
        i_dm_address   = 32'h0;
        i_dm_wdata     = 32'h0;
        i_dm_we        = 4'b0000;
        mmu_input_data = 32'h0;
        mmu_ready      = 1'b0;
    endtask

    task automatic test_reset();
        tick();
        tick();
        n_cmp++;
        if ({mmu_req, mmu_we, o_busy, o_if_ack, o_if_err, o_dm_ack, o_dm_err} !== 10'h0) begin
            n_err++;
            $display("[TB] FAIL reset_ctrl: got %b expected 0", {mmu_req, mmu_we, o_busy, o_if_ack, o_if_err, o_dm_ack, o_dm_err});
        end
        n_cmp++;
        if ({mmu_address, mmu_output_data} !== 64'h0) begin
            n_err++;
            $display("[TB] FAIL reset_mmu_regs: got %h expected 0", {mmu_address, mmu_output_data});
        end
        n_cmp++;
        if ({o_if_rdata, o_dm_rdata} !== 64'h0) begin
            n_err++;
            $display("[TB] FAIL reset_rdata: got %h expected 0", {o_if_rdata, o_dm_rdata});
        end
        reset = 1'b1;
        tick();
        n_cmp++;
        if ({o_busy, mmu_req} !== 2'b00) begin
            n_err++;
            $display("[TB] FAIL idle_after_reset: got %b expected 00", {o_busy, mmu_req});
        end
    endtask

    task automatic test_if_fetch();
        int rise = -1;
        int rdy_at = -1;
        int ack_at = -1;
        int acks = 0;
        int we_bad = 0;
        logic [31:0] addr_seen = 32'h0;
        logic [31:0] rd = 32'h0;
        logic er = 1'b1;
        i_if_req     = 1'b1;
        i_if_address = 32'h0000_0100;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (mmu_we !== 4'b0000) we_bad++;
            if (o_if_ack === 1'b1) begin
                acks++;
                ack_at   = c;
                rd       = o_if_rdata;
                er       = o_if_err;
                i_if_req = 1'b0;
            end
            if (mmu_req === 1'b1 && rise < 0) begin
                rise      = c;
                addr_seen = mmu_address;
            end
            if (rise >= 0 && c == rise + 2) begin
                mmu_ready      = 1'b1;
                mmu_input_data = 32'hDEADBEEF;
                rdy_at         = c;
            end else begin
                mmu_ready      = 1'b0;
                mmu_input_data = 32'h0;
            end
        end
        n_cmp++;
        if (rise !== 1) begin n_err++; $display("[TB] FAIL if_req_latency: got %0d expected 1", rise); end
        n_cmp++;
        if (addr_seen !== 32'h100) begin n_err++; $display("[TB] FAIL if_address: got %h expected 00000100", addr_seen); end
        n_cmp++;
        if (we_bad !== 0) begin n_err++; $display("[TB] FAIL if_we_zero: got %0d bad cycles expected 0", we_bad); end
        n_cmp++;
        if (acks !== 1) begin n_err++; $display("[TB] FAIL if_ack_count: got %0d expected 1", acks); end
        n_cmp++;
        if (ack_at !== rdy_at + 1) begin n_err++; $display("[TB] FAIL if_ack_timing: got %0d expected %0d", ack_at, rdy_at + 1); end
        n_cmp++;
        if ({er, rd} !== {1'b0, 32'hDEADBEEF}) begin n_err++; $display("[TB] FAIL if_rdata_err: got %b/%h expected 0/deadbeef", er, rd); end
        n_cmp++;
        if (o_busy !== 1'b0) begin n_err++; $display("[TB] FAIL if_idle_end: got %b expected 0", o_busy); end
    endtask

    task automatic test_dm_store();
        i_dm_req     = 1'b1;
        i_dm_address = 32'h0000_2000;
        i_dm_wdata   = 32'h1234_5678;
        i_dm_we      = 4'b0011;
        tick();
        n_cmp++;
        if ({mmu_req, mmu_we, mmu_output_data, mmu_address, o_dm_ack} !== {1'b1, 4'b0011, 32'h12345678, 32'h2000, 1'b0}) begin
            n_err++;
            $display("[TB] FAIL dm_store_issue: got %b %b %h %h %b expected 1 0011 12345678 00002000 0",
                     mmu_req, mmu_we, mmu_output_data, mmu_address, o_dm_ack);
        end
        mmu_ready      = 1'b1;
        mmu_input_data = 32'hCAFEF00D;
        tick();
        n_cmp++;
        if ({o_dm_ack, o_dm_err, mmu_req, mmu_we} !== {1'b1, 1'b0, 1'b0, 4'b0000}) begin
            n_err++;
            $display("[TB] FAIL dm_store_ack: got ack=%b err=%b req=%b we=%b expected 1 0 0 0000", o_dm_ack, o_dm_err, mmu_req, mmu_we);
        end
        n_cmp++;
        if (o_dm_rdata !== 32'hCAFEF00D) begin n_err++; $display("[TB] FAIL dm_store_rdata: got %h expected cafef00d", o_dm_rdata); end
        idle_inputs();
        tick();
        n_cmp++;
        if ({o_dm_ack, o_busy} !== 2'b00) begin n_err++; $display("[TB] FAIL dm_store_ack_once: got %b expected 00", {o_dm_ack, o_busy}); end
    endtask

    task automatic test_starvation();
        int grants = 0;
        int starve = 0;
        int want;
        int got;
        bit stop = 1'b0;
        logic prev_req = 1'b0;
        i_if_req       = 1'b1;
        i_if_address   = 32'h0000_0100;
        i_dm_req       = 1'b1;
        i_dm_address   = 32'h0000_2000;
        i_dm_we        = 4'b0000;
        i_dm_wdata     = 32'h0;
        mmu_ready      = 1'b1;
        mmu_input_data = 32'h5A5A_0000;
        for (int c = 0; c < 80 && (i_if_req || i_dm_req); c++) begin
            tick();
            if (mmu_req === 1'b1 && prev_req === 1'b0 && !stop) begin
                // Model: DM wins unless it already took STARVE_LIMIT grants in a row.
                want   = (starve == STARVE_LIMIT) ? 0 : 1;
                got    = (mmu_address === 32'h2000) ? 1 : 0;
                starve = (want == 1) ? starve + 1 : 0;
                n_cmp++;
                if (got !== want) begin
                    n_err++;
                    $display("[TB] FAIL starve_grant%0d: got %s expected %s", grants, got ? "DM" : "IF", want ? "DM" : "IF");
                end
                grants++;
                if (grants == 8) stop = 1'b1;
            end
            if (stop && o_if_ack === 1'b1) i_if_req = 1'b0;
            if (stop && o_dm_ack === 1'b1) i_dm_req = 1'b0;
            prev_req = mmu_req;
        end
        n_cmp++;
        if (grants !== 8) begin n_err++; $display("[TB] FAIL starve_grant_count: got %0d expected 8", grants); end
        n_cmp++;
        if ({i_if_req, i_dm_req} !== 2'b00) begin n_err++; $display("[TB] FAIL starve_drain: got %b pending expected 00", {i_if_req, i_dm_req}); end
        idle_inputs();
        tick();
        tick();
    endtask

    task automatic test_timeout();
        int high = 0;
        int acks = 0;
        int ack_at = -1;
        logic [31:0] wd = 32'hFFFF_FFFF;
        logic [31:0] rd = 32'hFFFF_FFFF;
        logic er = 1'b0;
        i_dm_req     = 1'b1;
        i_dm_address = 32'h0000_3000;
        i_dm_we      = 4'b0000;
        i_dm_wdata   = 32'hFFFF_0000;
        mmu_ready    = 1'b0;
        for (int c = 1; c <= 14; c++) begin
            tick();
            if (mmu_req === 1'b1) begin
                high++;
                if (high == 1) wd = mmu_output_data;
            end
            if (o_dm_ack === 1'b1) begin
                acks++;
                ack_at   = c;
                rd       = o_dm_rdata;
                er       = o_dm_err;
                i_dm_req = 1'b0;
            end
        end
        n_cmp++;
        if (high !== TIMEOUT_CYCLES) begin n_err++; $display("[TB] FAIL tmo_req_cycles: got %0d expected %0d", high, TIMEOUT_CYCLES); end
        n_cmp++;
        if (acks !== 1 || ack_at !== TIMEOUT_CYCLES + 1) begin
            n_err++;
            $display("[TB] FAIL tmo_ack: got %0d acks at %0d expected 1 at %0d", acks, ack_at, TIMEOUT_CYCLES + 1);
        end
        n_cmp++;
        if ({er, rd} !== {1'b1, 32'h0}) begin n_err++; $display("[TB] FAIL tmo_err_rdata: got %b/%h expected 1/00000000", er, rd); end
        n_cmp++;
        if (wd !== 32'h0) begin n_err++; $display("[TB] FAIL load_wdata_zero: got %h expected 00000000", wd); end
        n_cmp++;
        if (o_busy !== 1'b0) begin n_err++; $display("[TB] FAIL tmo_idle: got %b expected 0", o_busy); end
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        int acks = 0;
        int ack_at = -1;
        logic [31:0] rd = 32'h0;
        i_dm_req     = 1'b1;
        i_dm_address = 32'h0000_4000;
        i_dm_we      = 4'b1111;
        i_dm_wdata   = 32'hA5A5_A5A5;
        mmu_ready    = 1'b0;
        tick();
        tick();
        n_cmp++;
        if ({mmu_req, o_busy} !== 2'b11) begin n_err++; $display("[TB] FAIL rstmid_busy: got %b expected 11", {mmu_req, o_busy}); end
        #2 reset = 1'b0;
        #1;
        n_cmp++;
        if ({mmu_req, mmu_we, o_busy, mmu_address} !== 38'h0) begin
            n_err++;
            $display("[TB] FAIL rstmid_async: got req=%b we=%b busy=%b addr=%h expected all 0", mmu_req, mmu_we, o_busy, mmu_address);
        end
        idle_inputs();
        tick();
        reset = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (o_dm_ack === 1'b1 || o_if_ack === 1'b1) acks++;
        end
        n_cmp++;
        if (acks !== 0) begin n_err++; $display("[TB] FAIL rstmid_no_ack: got %0d acks expected 0", acks); end
        i_if_req       = 1'b1;
        i_if_address   = 32'h0000_0500;
        mmu_ready      = 1'b1;
        mmu_input_data = 32'h0BAD_F00D;
        for (int c = 1; c <= 10; c++) begin
            tick();
            if (o_if_ack === 1'b1 && ack_at < 0) begin
                ack_at   = c;
                rd       = o_if_rdata;
                i_if_req = 1'b0;
            end
        end
        n_cmp++;
        if (ack_at !== 2 || rd !== 32'h0BAD_F00D) begin
            n_err++;
            $display("[TB] FAIL rstmid_recover: got ack at %0d data %h expected 2 / 0badf00d", ack_at, rd);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_back_to_back();
        int rises[$];
        int acks = 0;
        int spacing;
        logic prev_req = 1'b0;
        i_dm_req       = 1'b1;
        i_dm_address   = 32'h0000_6000;
        i_dm_we        = 4'b1100;
        i_dm_wdata     = 32'h1111_2222;
        mmu_ready      = 1'b1;
        mmu_input_data = 32'h7777_8888;
        for (int c = 1; c <= 20 && i_dm_req; c++) begin
            tick();
            if (mmu_req === 1'b1 && prev_req === 1'b0) rises.push_back(c);
            if (o_dm_ack === 1'b1) begin
                acks++;
                if (acks == 2) i_dm_req = 1'b0;
            end
            prev_req = mmu_req;
        end
        spacing = (rises.size() >= 2) ? rises[1] - rises[0] : -1;
        n_cmp++;
        if (rises.size() !== 2 || spacing !== 3) begin
            n_err++;
            $display("[TB] FAIL b2b_spacing: got %0d grants spacing %0d expected 2 / 3", rises.size(), spacing);
        end
        idle_inputs();
        tick();
        tick();
        acks = 0;
        mmu_ready      = 1'b1;
        mmu_input_data = 32'hFFFF_FFFF;
        tick();
        mmu_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            if (o_dm_ack === 1'b1 || o_if_ack === 1'b1 || o_busy === 1'b1) acks++;
            tick();
        end
        n_cmp++;
        if (acks !== 0) begin n_err++; $display("[TB] FAIL stray_ready: got %0d active cycles expected 0", acks); end
    endtask

    task automatic test_random();
        logic if_pend = 1'b0;
        logic dm_pend = 1'b0;
        logic prev_if = 1'b0;
        logic prev_dm = 1'b0;
        logic prev_req = 1'b0;
        logic [31:0] if_addr = 32'h0;
        logic [31:0] dm_addr = 32'h0;
        logic [31:0] dm_wd = 32'h0;
        logic [3:0]  dm_we = 4'b0000;
        logic [31:0] resp_data = 32'h0;
        logic [67:0] exp_fields;
        logic exp_if_ack;
        logic exp_dm_ack;
        bit   resp = 1'b0;
        int   starve = 0;
        int   inflight = 0;
        int   delay = 0;
        int   issued = 0;
        int   done = 0;
        int   want;
        for (int c = 0; c < 400; c++) begin
            tick();
            exp_if_ack = resp && (inflight == 1);
            exp_dm_ack = resp && (inflight == 2);
            n_cmp++;
            if (o_if_ack !== exp_if_ack) begin n_err++; $display("[TB] FAIL rnd_if_ack@%0d: got %b expected %b", c, o_if_ack, exp_if_ack); end
            n_cmp++;
            if (o_dm_ack !== exp_dm_ack) begin n_err++; $display("[TB] FAIL rnd_dm_ack@%0d: got %b expected %b", c, o_dm_ack, exp_dm_ack); end
            if (exp_if_ack) begin
                n_cmp++;
                if ({o_if_err, o_if_rdata} !== {1'b0, resp_data}) begin
                    n_err++;
                    $display("[TB] FAIL rnd_if_data@%0d: got %b/%h expected 0/%h", c, o_if_err, o_if_rdata, resp_data);
                end
            end
            if (exp_dm_ack) begin
                n_cmp++;
                if ({o_dm_err, o_dm_rdata} !== {1'b0, resp_data}) begin
                    n_err++;
                    $display("[TB] FAIL rnd_dm_data@%0d: got %b/%h expected 0/%h", c, o_dm_err, o_dm_rdata, resp_data);
                end
            end
            if (resp) begin
                if (inflight == 1) if_pend = 1'b0;
                else dm_pend = 1'b0;
                done++;
                inflight = 0;
                resp = 1'b0;
            end
            if (mmu_req === 1'b1 && prev_req === 1'b0) begin
                n_cmp++;
                if (inflight != 0 || !(prev_if || prev_dm)) begin
                    n_err++;
                    $display("[TB] FAIL rnd_spurious_grant@%0d: got grant expected none", c);
                end else begin
                    want = (prev_dm && !(prev_if && starve == STARVE_LIMIT)) ? 2 : 1;
                    if (want == 2) starve = prev_if ? ((starve < STARVE_LIMIT) ? starve + 1 : starve) : 0;
                    else starve = 0;
                    exp_fields = (want == 1) ? {if_addr, 4'b0000, 32'h0}
                                             : {dm_addr, dm_we, (dm_we == 4'b0000) ? 32'h0 : dm_wd};
                    n_cmp++;
                    if ({mmu_address, mmu_we, mmu_output_data} !== exp_fields) begin
                        n_err++;
                        $display("[TB] FAIL rnd_grant@%0d: got %h expected %h (%s)", c, {mmu_address, mmu_we, mmu_output_data},
                                 exp_fields, (want == 1) ? "IF" : "DM");
                    end
                    inflight = want;
                    delay    = $urandom_range(0, 3);
                end
            end
            if (inflight != 0 && !resp && mmu_req === 1'b1) begin
                if (delay == 0) begin
                    resp_data      = $urandom;
                    mmu_input_data = resp_data;
                    mmu_ready      = 1'b1;
                    resp           = 1'b1;
                end else begin
                    delay--;
                    mmu_ready      = 1'b0;
                    mmu_input_data = $urandom;
                end
            end else begin
                mmu_ready      = (mmu_req === 1'b0) && ($urandom_range(0, 7) == 0);
                mmu_input_data = $urandom;
            end
            if (c < 360) begin
                if (!if_pend && $urandom_range(0, 2) == 0) begin
                    if_pend = 1'b1;
                    if_addr = $urandom;
                    issued++;
                end
                if (!dm_pend && $urandom_range(0, 2) == 0) begin
                    dm_pend = 1'b1;
                    dm_addr = $urandom;
                    dm_we   = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom);
                    dm_wd   = $urandom;
                    issued++;
                end
            end
            i_if_req     = if_pend;
            i_if_address = if_addr;
            i_dm_req     = dm_pend;
            i_dm_address = dm_addr;
            i_dm_we      = dm_we;
            i_dm_wdata   = dm_wd;
            prev_if      = if_pend;
            prev_dm      = dm_pend;
            prev_req     = mmu_req;
        end
        n_cmp++;
        if (done !== issued || if_pend || dm_pend) begin
            n_err++;
            $display("[TB] FAIL rnd_completion: got %0d done expected %0d issued", done, issued);
        end
        idle_inputs();
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        #2 reset = 1'b0;
        test_reset();
        test_if_fetch();
        test_dm_store();
        test_starvation();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mmu_port_arbiter.md
Name: mmu_port_arbiter

Overview:
- Shares the single MMU data port between the instruction-fetch requester (IF) and the memory-stage requester (DM).
- Registers the winning request and drives the MMU address, write data and byte enables. Waits a variable number of cycles for the MMU ready signal, then returns read data with a one-cycle ack.
- DM has fixed priority over IF. A starvation counter guarantees that IF is served periodically.
- A timeout aborts hung MMU transactions and reports an error to the requester.

Parameters:
- STARVE_LIMIT, 4: max consecutive DM grants while IF is pending before IF is forced through; legal range ≥1.
- TIMEOUT_CYCLES, 64: cycles in BUSY without mmu_ready before abort; legal range ≥2.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- i_if_req  in  1  IF request; held with i_if_address until o_if_ack
- i_if_address  in  32  IF word address
- o_if_rdata  out  32  IF read data, valid while o_if_ack=1
- o_if_ack  out  1  one-cycle IF completion pulse
- o_if_err  out  1  IF timeout flag, valid with o_if_ack
- i_dm_req  in  1  DM request; held with all i_dm_* inputs until o_dm_ack
- i_dm_address  in  32  DM address
- i_dm_wdata  in  32  DM store data
- i_dm_we  in  4  DM byte enables; 0 = load
- o_dm_rdata  out  32  DM read data, valid while o_dm_ack=1
- o_dm_ack  out  1  one-cycle DM completion pulse
- o_dm_err  out  1  DM timeout flag, valid with o_dm_ack
- mmu_req  out  1  transaction active toward MMU
- mmu_address  out  32  registered address
- mmu_output_data  out  32  registered store data
- mmu_we  out  4  registered byte enables
- mmu_input_data  in  32  MMU read data, sampled when mmu_ready=1
- mmu_ready  in  1  MMU completes the current transaction this cycle
- o_busy  out  1  state != IDLE

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE.
  - All outputs are 0: mmu_req, mmu_address, mmu_output_data, mmu_we, acks, errs, rdata, o_busy.
  - starve_cnt=0, tmo_cnt=0.
  - Reset asserted mid-transaction drops mmu_req immediately and discards the transaction; no ack is issued.
- FSM states: IDLE, BUSY_IF, BUSY_DM, ACK. All outputs are registered.
- IDLE arbitration, one decision per cycle:
  - Neither request: stay IDLE.
  - Only one request: grant it.
  - Both requesting: grant DM unless starve_cnt==STARVE_LIMIT, in which case grant IF.
  - On a grant, latch the requester's fields into the mmu_* registers and go to BUSY_x.
  - IF grants force mmu_we=0 and mmu_output_data=0.
  - DM loads (i_dm_we=0) force mmu_output_data=0.
- starve_cnt:
  - Increments on a DM grant while i_if_req=1, saturating at STARVE_LIMIT.
  - Clears on any IF grant, and on a DM grant with i_if_req=0.
- BUSY_x:
  - mmu_req=1; the mmu_* registers are stable; tmo_cnt increments each cycle.
  - mmu_ready=1 in a BUSY cycle (including the first one):
    - capture mmu_input_data into o_x_rdata;
    - assert o_x_ack=1 and o_x_err=0 for the next cycle;
    - go to ACK;
    - clear mmu_req, mmu_we and mmu_output_data.
  - mmu_ready=0 and tmo_cnt==TIMEOUT_CYCLES-1: abort.
    - o_x_ack=1, o_x_err=1, o_x_rdata=0; go to ACK.
    - Clear mmu_req and mmu_we.
  - tmo_cnt clears on every entry to BUSY.
  - mmu_ready in IDLE or ACK is ignored.
- ACK:
  - Exactly one cycle; the acks are held only here.
  - Requests are not sampled in ACK; a requester may keep req high for a back-to-back transaction.
  - Transitions to IDLE, where the next request is arbitrated.
- Latency: request first seen in IDLE at cycle N → mmu_req at N+1 → with mmu_ready at N+1, ack at N+2. Best-case throughput is one transaction per 3 cycles.
- mmu_address, mmu_output_data and mmu_we retain their last values in IDLE and ACK, except that mmu_we is forced to 0 whenever mmu_req=0.
- The non-granted requester sees ack=0 and keeps waiting; its inputs must stay stable.

Test Plan:
- Single IF fetch:
  - Stimulus: i_if_req=1, address 0x0000_0100; mmu_ready pulses 2 cycles after mmu_req rises, mmu_input_data=0xDEADBEEF.
  - Required: mmu_we=0 throughout; o_if_rdata=0xDEADBEEF with o_if_ack=1 for exactly one cycle, on the cycle after mmu_ready; o_if_err=0.
- DM store:
  - Stimulus: i_dm_we=4'b0011, address 0x2000, i_dm_wdata=0x1234_5678; mmu_ready on the first BUSY cycle.
  - Required: mmu_we=4'b0011 and mmu_output_data=0x12345678 for one cycle; o_dm_ack one cycle later; then mmu_we=0.
- Contention with starvation, STARVE_LIMIT=4:
  - Stimulus: both requests held high continuously; mmu_ready=1 immediately.
  - Required: grant order DM,DM,DM,DM,IF,DM… ; IF is served on the 5th grant.
- Timeout, TIMEOUT_CYCLES=8:
  - Stimulus: DM load with mmu_ready held at 0.
  - Required: mmu_req high for 8 cycles, then drops; o_dm_ack=1, o_dm_err=1, o_dm_rdata=0; FSM returns to IDLE.
- Reset mid-transaction:
  - Stimulus: reset=0 asserted while in BUSY_DM.
  - Required: mmu_req=0 and mmu_we=0 immediately (asynchronous, no clock edge needed); no ack after release; a subsequent IF request completes normally.
- Back-to-back and stray ready:
  - Stimulus: i_dm_req held high through ACK; also a stray mmu_ready pulse while IDLE.
  - Required: the second DM transaction starts on the cycle after IDLE (a 3-cycle spacing); the stray ready produces no ack.
